// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Combinational only; no latency or backpressure of its own.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_IF = 2'd1,
        REQ_DM = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshake buses of the port arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;

    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_ready_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dmem_port_arbiter_arb_watchdog.sv
// Access watchdog: counts request-state cycles, pulses expired_o on the last allowed one.
// Expiry is combinational from the count; no backpressure.
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one memory port; MEMARB_ROUND_ROBIN_EN selects fair arbitration.
// Ready pulses 2 cycles after grant at zero wait states (+1 per wait); requesters stall until their ready pulse.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [DW-1:0] ERR_DATA  = DW'(ERR_DATA_DEF)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_port_arbiter_if.slave    bus,
    output logic                  grant_o,
    output logic                  busy_o,
    output logic                  err_o
);
    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant_q, grant_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          pick_dm;
    logic          in_req;
    logic          expired;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic          last_grant_q, last_grant_d;
`endif

    assign in_req = (state_q == REQ_IF) || (state_q == REQ_DM);

    arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!in_req),
        .inc_i     (in_req),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
`ifdef MEMARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        pick_dm      = bus.dm_req_i && (!bus.if_req_i || (last_grant_q == GRANT_IF));
`else
        pick_dm      = bus.dm_req_i;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_dm) begin
                    we_d    = bus.dm_we_i;
                    addr_d  = bus.dm_addr_i;
                    wdata_d = bus.dm_wdata_i;
                    grant_d = GRANT_DM;
                    state_d = REQ_DM;
                end else if (bus.if_req_i) begin
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr_i;
                    grant_d = GRANT_IF;
                    state_d = REQ_IF;
                end
            end
            REQ_IF, REQ_DM: begin
                // An ack on the final watchdog cycle still counts as a clean completion.
                if (bus.mem_ack_i || expired) begin
                    state_d = RESP;
`ifdef MEMARB_ROUND_ROBIN_EN
                    last_grant_d = grant_q;
`endif
                    if (!bus.mem_ack_i) begin
                        err_d = 1'b1;
                        if (grant_q == GRANT_DM) dm_rdata_d = ERR_DATA;
                        else                     if_rdata_d = ERR_DATA;
                    end else if (!we_q) begin
                        if (grant_q == GRANT_DM) dm_rdata_d = bus.mem_rdata_i;
                        else                     if_rdata_d = bus.mem_rdata_i;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.mem_req_o   = in_req;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_ready_o  = (state_q == RESP) && (grant_q == GRANT_IF);
    assign bus.dm_ready_o  = (state_q == RESP) && (grant_q == GRANT_DM);
    assign grant_o         = grant_q;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table plus multi-cycle corner sequences.
module tb_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic grant, busy, err;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT_CYC(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ifr;
        logic [31:0] ifd;
        logic        dmr;
        logic [31:0] dmd;
        logic        grant;
        logic        busy;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [31:0] C = 32'h8C080004;
    localparam logic [31:0] S = 32'h12345678;

    vec_t vt [15];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic g_seen [4];

    task automatic apply(input in_t v);
        rst             = v.rst;
        bus.if_req_i    = v.if_req;
        bus.if_addr_i   = v.if_addr;
        bus.dm_req_i    = v.dm_req;
        bus.dm_we_i     = v.dm_we;
        bus.dm_addr_i   = v.dm_addr;
        bus.dm_wdata_i  = v.dm_wdata;
        bus.mem_ack_i   = v.ack;
        bus.mem_rdata_i = v.rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t get_out();
        return '{bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
                 bus.if_ready_o, bus.if_rdata_o, bus.dm_ready_o, bus.dm_rdata_o,
                 grant, busy, err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input out_t exp);
        out_t act;
        act = get_out();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        apply('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        // rst, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ack, rdata
        // req, we, addr, wdata, ifr, ifd, dmr, dmd, grant, busy, err
        vt[0]  = '{'{1'b0,1'b1,32'h40,1'b1,1'b1,32'h100,32'h55,1'b1,C},
                   '{1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,1'b0}};
        vt[1]  = vt[0];
        vt[2]  = '{'{1'b1,1'b1,32'h40,1'b0,1'b0,32'h0,32'h0,1'b1,C},
                   '{1'b1,1'b0,32'h40,32'h0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,1'b0}};
        vt[3]  = '{'{1'b1,1'b1,32'h40,1'b0,1'b0,32'h0,32'h0,1'b1,C},
                   '{1'b0,1'b0,32'h40,32'h0,1'b1,C,1'b0,32'h0,1'b0,1'b1,1'b0}};
        vt[4]  = '{'{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0},
                   '{1'b0,1'b0,32'h40,32'h0,1'b0,C,1'b0,32'h0,1'b0,1'b0,1'b0}};
        vt[5]  = '{'{1'b1,1'b0,32'h0,1'b1,1'b1,32'h100,S,1'b0,32'h0},
                   '{1'b1,1'b1,32'h100,S,1'b0,C,1'b0,32'h0,1'b1,1'b1,1'b0}};
        vt[6]  = vt[5];
        vt[7]  = vt[5];
        vt[8]  = vt[5];
        vt[9]  = '{'{1'b1,1'b0,32'h0,1'b1,1'b1,32'h100,S,1'b1,32'hFFFF0000},
                   '{1'b0,1'b1,32'h100,S,1'b0,C,1'b1,32'h0,1'b1,1'b1,1'b0}};
        vt[10] = '{'{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0},
                   '{1'b0,1'b1,32'h100,S,1'b0,C,1'b0,32'h0,1'b1,1'b0,1'b0}};
        vt[11] = '{'{1'b1,1'b0,32'h0,1'b1,1'b0,32'h300,32'h0,1'b1,32'hAAAA5555},
                   '{1'b1,1'b0,32'h300,32'h0,1'b0,C,1'b0,32'h0,1'b1,1'b1,1'b0}};
        vt[12] = '{'{1'b1,1'b0,32'h0,1'b1,1'b0,32'h300,32'h0,1'b1,32'h0BADF00D},
                   '{1'b0,1'b0,32'h300,32'h0,1'b0,C,1'b1,32'h0BADF00D,1'b1,1'b1,1'b0}};
        vt[13] = '{'{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h0},
                   '{1'b0,1'b0,32'h300,32'h0,1'b0,C,1'b0,32'h0BADF00D,1'b1,1'b0,1'b0}};
        vt[14] = vt[13];

        idle_in();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply(vt[i].i);
            step();
            chk_out($sformatf("vec%0d", i), vt[i].o);
        end

        // Contention with explicit handshakes: DM first, IF ready 3 cycles later.
        do_reset();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h304;
        step();
`ifdef MEMARB_ROUND_ROBIN_EN
        chk("cont_first_grant", {31'd0, grant}, 32'd1);
`else
        chk("cont_first_grant", {31'd0, grant}, 32'd1);
`endif
        chk("cont_first_addr", bus.mem_addr_o, 32'h304);
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h11;
        step();
        chk("cont_dm_ready", {30'd0, bus.dm_ready_o, bus.if_ready_o}, 32'd2);
        bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b0;
        step();
        chk("cont_idle_gap", {31'd0, busy}, 32'd0);
        step();
        chk("cont_if_grant", {30'd0, bus.mem_req_o, grant}, 32'd2);
        chk("cont_if_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h22;
        step();
        chk("cont_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        chk("cont_if_rdata", bus.if_rdata_o, 32'h22);

        // Both requests held with a zero-wait memory: record grant per access.
        do_reset();
        bus.if_req_i = 1'b1; bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0;
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h33;
        begin
            int k = 0;
            for (int c = 0; c < 20 && k < 4; c++) begin
                step();
                if (bus.mem_req_o) begin
                    g_seen[k] = grant;
                    k++;
                end
            end
            chk("held_access_count", k, 4);
            for (int j = 0; j < 4 && j < k; j++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
                chk($sformatf("rr_grant%0d", j), {31'd0, g_seen[j]}, (j % 2 == 0) ? 32'd1 : 32'd0);
`else
                chk($sformatf("prio_grant%0d", j), {31'd0, g_seen[j]}, 32'd1);
`endif
            end
        end

        // Ack on the final watchdog cycle wins over the timeout.
        do_reset();
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h400;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        chk("tw_still_req", {31'd0, bus.mem_req_o}, 32'd1);
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h77;
        step();
        chk("tw_ready", {31'd0, bus.dm_ready_o}, 32'd1);
        chk("tw_rdata", bus.dm_rdata_o, 32'h77);
        chk("tw_no_err", {31'd0, err}, 32'd0);
        bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b0;
        step();

        // Real timeout: ERR_DATA returned, err sticky until reset.
        bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h500;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        chk("to_req_held", {30'd0, bus.mem_req_o, err}, 32'd2);
        step();
        chk("to_ready", {30'd0, bus.dm_ready_o, bus.mem_req_o}, 32'd2);
        chk("to_rdata", bus.dm_rdata_o, 32'hDEADBEEF);
        chk("to_err", {31'd0, err}, 32'd1);
        bus.dm_req_i = 1'b0;
        step();
        chk("to_idle", {30'd0, busy, bus.dm_ready_o}, 32'd0);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40; bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h44;
        step();
        step();
        chk("to_fetch_ready", {31'd0, bus.if_ready_o}, 32'd1);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        step();
        chk("to_err_cleared", {31'd0, err}, 32'd0);

        // Reset during REQ_DM: no ready, late ack ignored.
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h600;
        step();
        chk("mr_in_req", {30'd0, busy, bus.mem_req_o}, 32'd3);
        rst = 1'b0;
        step();
        chk_out("mr_reset_outs", '0);
        rst = 1'b1; bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h99;
        step();
        chk("mr_late_ack", {30'd0, busy, bus.dm_ready_o}, 32'd0);
        chk("mr_rdata", bus.dm_rdata_o, 32'h0);
        step();
        chk("mr_no_ready", {30'd0, busy, bus.dm_ready_o}, 32'd0);
        bus.mem_ack_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sits between the pipeline and the memory. It sequences each access through a request/acknowledge handshake with the memory.
- It returns a one-cycle ready pulse to the requester that was served. A requester stalls its own stage until it sees that pulse.
- Includes a watchdog that aborts a memory access that never completes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 64, cycles in a request state without mem_ack_i before the access is aborted.
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted access.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-low.
- if_req_i  in  1  fetch request. Held together with if_addr_i until if_ready_o.
- if_addr_i  in  AW  fetch address.
- if_rdata_o  out  DW  fetched instruction. Valid while if_ready_o=1.
- if_ready_o  out  1  one-cycle completion pulse for a fetch.
- dm_req_i  in  1  data request. Held together with the other dm_* inputs until dm_ready_o.
- dm_we_i  in  1  1=store, 0=load.
- dm_addr_i  in  AW  data address.
- dm_wdata_i  in  DW  store data.
- dm_rdata_o  out  DW  load data. Valid while dm_ready_o=1.
- dm_ready_o  out  1  one-cycle completion pulse for a data access.
- mem_req_o  out  1  memory request. Held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data. Valid with mem_ack_i.
- mem_ack_i  in  1  memory completion. One cycle. May arrive in the same cycle as mem_req_o first rises.
- grant_o  out  1  owner of the current access: 0=IF, 1=DM.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - state goes to IDLE and the timeout counter clears.
  - Every output goes to 0, including err_o, if_rdata_o and dm_rdata_o.
  - Reset in the middle of an access drops mem_req_o on the next edge. No ready pulse is issued for that access.
- States: IDLE, REQ_IF, REQ_DM, RESP.
- IDLE:
  - dm_req_i=1: latch dm_we_i, dm_addr_i and dm_wdata_i into the mem_* registers, set grant_o=1, go to REQ_DM.
  - Otherwise, if if_req_i=1: latch if_addr_i, set mem_we_o=0 and grant_o=0, go to REQ_IF.
  - Data priority is the default arbitration rule. It avoids deadlock, because a stalled MEM stage also stalls IF.
  - A mem_ack_i that arrives while in IDLE is ignored.
- REQ_IF / REQ_DM:
  - mem_req_o=1. Address, write data and write enable are registered and stay stable for the whole state.
  - On mem_ack_i=1: capture mem_rdata_i into the owner's rdata register (stores capture nothing), clear mem_req_o, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC-1 with no ack: load ERR_DATA into the owner's rdata, set err_o, clear mem_req_o, go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins and err_o is not set.
- RESP:
  - Exactly one cycle. The owner's ready output is 1, then the state returns to IDLE.
  - The rdata outputs hold their value until the next capture.
- Requesters sample ready at the clock edge and present their next request from the following cycle. Returning to IDLE after RESP therefore prevents the same request from being granted twice.
- If a requester drops its req during an access, the access still completes and the ready pulse is still issued.
- Latency: a request in IDLE at cycle 0 with mem_ack_i at cycle 1 gives ready at cycle 2.
  - Throughput is 1 access per 3 cycles at zero wait states.
  - Each memory wait cycle adds 1 cycle.
- Timeout counter width: $clog2(TIMEOUT_CYC). It clears on every entry to a REQ state.

Optional Feature:
- MEMARB_ROUND_ROBIN_EN defined:
  - A 1-bit last_grant register, reset to 0.
  - When both requests are present in IDLE, grant the requester that was not served last.
  - When only one request is present, grant it.
  - last_grant updates on entry to RESP.
- Not defined: fixed data priority as described above; no last_grant register.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ_IF, REQ_DM, RESP);
  - the GRANT_IF=0 and GRANT_DM=1 constants;
  - the default ERR_DATA constant.
- One sub-module: arb_watchdog. It contains the clear/increment counter and outputs a single expired pulse.

Test Plan:
- Reset hold:
  - Stimulus: assert rst_i=0 with mem_ack_i=1 and both reqs active.
  - Expected: every output is 0.
  - Then release reset with only if_req_i, if_addr_i=0x40, mem_ack_i tied 1 and mem_rdata_i=0x8C080004.
  - Expected: mem_addr_o=0x40 at cycle 1; if_ready_o=1 with if_rdata_o=0x8C080004 at cycle 2.
- Store with wait states:
  - Stimulus: dm_req_i=1, dm_we_i=1, dm_addr_i=0x100, dm_wdata_i=0x12345678; mem_ack_i arrives 3 cycles after mem_req_o.
  - Expected: mem_we_o=1 and the mem_* outputs stay stable for 4 cycles; dm_ready_o pulses for 1 cycle on the following cycle.
- Contention, fixed priority:
  - Stimulus: if_req_i and dm_req_i asserted in the same cycle.
  - Expected: DM is served first (grant_o=1), then IF; IF waits 3 extra cycles.
- Contention with MEMARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requests held continuously.
  - Expected: grant_o alternates 1,0,1,0 across successive accesses.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8, mem_ack_i never asserted on a load.
  - Expected: dm_ready_o pulses with dm_rdata_o=0xDEADBEEF; err_o=1 and stays 1 until reset.
- Reset mid-access:
  - Stimulus: rst_i=0 for one cycle in REQ_DM, then mem_ack_i arrives.
  - Expected: no dm_ready_o pulse, state is IDLE, and the late ack is ignored.
